// File: rtl/circuit_f3_pkg.sv
// Shared constants and the truth-table lookup used by the circuit_f3 block.
package circuit_f3_pkg;

  localparam logic [3:0] TRUTH_XOR = 4'b0110;
  localparam logic [3:0] TRUTH_AND = 4'b1000;
  localparam int         CNT_W_DEF = 8;

  // Index is {a,b}: a selects the upper pair of table bits.
  function automatic logic lut_lookup(input logic [3:0] truth, input logic a, input logic b);
    logic [1:0] idx;
    idx = {a, b};
    return truth[idx];
  endfunction

endpackage

// File: rtl/circuit_f3_lut.sv
// Pure combinational 4:1 truth-table lookup, y = TRUTH[{a,b}].
module circuit_f3_lut
  import circuit_f3_pkg::*;
#(
  parameter logic [3:0] TRUTH = TRUTH_XOR
) (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = lut_lookup(TRUTH, a, b);

endmodule

// File: rtl/circuit_f3.sv
// Two-input Boolean function unit: registered F(a,b) with valid strobe,
// plus a saturating count of results that evaluated to 1.
module circuit_f3
  import circuit_f3_pkg::*;
#(
  parameter logic [3:0] TRUTH = TRUTH_XOR,
  parameter int         CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  output logic             f3,
  output logic             out_valid,
  output logic             f3_comb,
  output logic [CNT_W-1:0] ones_cnt
);

  logic             lut_y;
  logic             f3_d, f3_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // One lookup feeds both the unregistered monitor output and the result flop.
  circuit_f3_lut #(.TRUTH(TRUTH)) u_lut (
    .a (a),
    .b (b),
    .y (lut_y)
  );

  always_comb begin
    f3_d        = f3_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    if (in_valid) begin
      f3_d        = lut_y;
      out_valid_d = 1'b1;
      if (lut_y && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      f3_q        <= f3_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign f3        = f3_q;
  assign out_valid = out_valid_q;
  assign f3_comb   = lut_y;
  assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_circuit_f3.sv
// Scoreboard bench for circuit_f3: default XOR unit, a 2-bit-counter unit and an AND unit.
module tb_circuit_f3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;

  logic       f3_0, ov0, fc0;
  logic [7:0] cnt0;
  logic       f3_1, ov1, fc1;
  logic [1:0] cnt1;
  logic       f3_2, ov2, fc2;
  logic [7:0] cnt2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic f3;
    int   cnt;
    int   cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  circuit_f3 #(.TRUTH(4'b0110), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(v0),
    .f3(f3_0), .out_valid(ov0), .f3_comb(fc0), .ones_cnt(cnt0));

  circuit_f3 #(.TRUTH(4'b0110), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(v1),
    .f3(f3_1), .out_valid(ov1), .f3_comb(fc1), .ones_cnt(cnt1));

  circuit_f3 #(.TRUTH(4'b1000), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(v2),
    .f3(f3_2), .out_valid(ov2), .f3_comb(fc2), .ones_cnt(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the edge so the next edge samples them cleanly.
  task automatic drive(input int inst, input logic ia, input logic ib,
                       input logic iv, input logic irst);
    @(posedge clk);
    #1;
    rst = irst;
    a   = ia;
    b   = ib;
    v0  = iv && (inst == 0);
    v1  = iv && (inst == 1);
    v2  = iv && (inst == 2);
  endtask

  // Result of the sample just driven shows up after the next edge.
  task automatic push(input int inst, input logic f, input int c);
    exp_t e;
    e.f3  = f;
    e.cnt = c;
    e.cyc = cyc + 1;
    if (inst == 0) q0.push_back(e);
    else if (inst == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov0) begin
      if (q0.size() == 0) chk("dut0 unexpected out_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0 f3", int'(f3_0), int'(e.f3));
        chk("dut0 ones_cnt", int'(cnt0), e.cnt);
        chk("dut0 latency cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov1) begin
      if (q1.size() == 0) chk("dut1 unexpected out_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1 f3", int'(f3_1), int'(e.f3));
        chk("dut1 ones_cnt", int'(cnt1), e.cnt);
        chk("dut1 latency cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov2) begin
      if (q2.size() == 0) chk("dut2 unexpected out_valid", 1, 0);
      else begin
        e = q2.pop_front();
        chk("dut2 f3", int'(f3_2), int'(e.f3));
        chk("dut2 ones_cnt", int'(cnt2), e.cnt);
        chk("dut2 latency cycle", cyc, e.cyc);
      end
    end
  end

  logic [1:0] sweep_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       xor_f    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int         xor_cnt  [4] = '{0, 1, 2, 2};
  logic       gap_a    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       gap_b    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       gap_comb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int         sat_cnt  [5] = '{1, 2, 3, 3, 3};
  logic       and_f    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int         and_cnt  [4] = '{0, 0, 0, 1};

  initial begin
    // Reset held for two edges with a valid sample pending; valid must not leak through.
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("reset f3", int'(f3_0), 0);
    chk("reset out_valid", int'(ov0), 0);
    chk("reset ones_cnt", int'(cnt0), 0);
    chk("reset f3_comb", int'(fc0), 1);

    // Exhaustive XOR sweep.
    for (int i = 0; i < 4; i++) begin
      drive(0, sweep_ab[i][1], sweep_ab[i][0], 1'b1, 1'b0);
      push(0, xor_f[i], xor_cnt[i]);
    end

    // Gap: registered state holds, combinational output tracks a^b.
    for (int i = 0; i < 4; i++) begin
      drive(0, gap_a[i], gap_b[i], 1'b0, 1'b0);
      #1;
      chk("gap f3_comb", int'(fc0), int'(gap_comb[i]));
      @(negedge clk);
      if (i > 0) begin
        chk("gap out_valid", int'(ov0), 0);
        chk("gap f3 hold", int'(f3_0), 0);
        chk("gap ones_cnt hold", int'(cnt0), 2);
      end
    end

    // Reset mid-sweep, then the sweep resumes from a cleared counter.
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(0, 1'b0, 2);
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(0, 1'b1, 3);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("midreset out_valid", int'(ov0), 0);
    chk("midreset ones_cnt", int'(cnt0), 0);
    chk("midreset f3", int'(f3_0), 0);
    rst = 1'b0;
    v0  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, sweep_ab[i][1], sweep_ab[i][0], 1'b1, 1'b0);
      push(0, xor_f[i], xor_cnt[i]);
    end

    // Saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
      push(1, 1'b1, sat_cnt[i]);
    end
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sat ones_cnt stays", int'(cnt1), 3);

    // AND table instance.
    for (int i = 0; i < 4; i++) begin
      drive(2, sweep_ab[i][1], sweep_ab[i][0], 1'b1, 1'b0);
      push(2, and_f[i], and_cnt[i]);
    end

    for (int i = 0; i < 4; i++) drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dut0 results outstanding", q0.size(), 0);
    chk("dut1 results outstanding", q1.size(), 0);
    chk("dut2 results outstanding", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
